// File: rtl/reg_bank.sv
// CPU register file: two combinational read ports, one synchronous write port with
// full/low-half/high-half modes, carry/overflow flags and a one-register-per-cycle clear sweep.
module reg_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit R0_ZERO = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              flag_we,
    input  logic              flag_c_in,
    input  logic              flag_v_in,
    output logic              flag_c,
    output logic              flag_v,
    input  logic              clr_start,
    output logic              busy,
    output logic              wr_drop
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int HALF     = DATA_W / 2;

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_LOW  = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;
    localparam logic [1:0] MODE_NOP  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] stored_word;
    logic [DATA_W-1:0] merge_data;
    logic              wr_accept;
    logic              wr_drop_next;
    logic              wr_to_r0;
    logic [NUM_REGS-1:0] clr_hit;
    logic [NUM_REGS-1:0] wr_hit;

    assign busy = (state_reg == ST_CLEAR);

    // Writes to a hard-wired zero register vanish without being reported as dropped.
    assign wr_to_r0     = R0_ZERO && (wr_addr == '0);
    assign wr_accept    = wr_en && !busy && (wr_mode != MODE_NOP) && !wr_to_r0;
    assign wr_drop_next = wr_en && (busy || (wr_mode == MODE_NOP));

    assign stored_word = regs[wr_addr];

    always_comb begin
        merge_data = stored_word;
        case (wr_mode)
            MODE_FULL: merge_data = wr_data;
            MODE_LOW:  merge_data = {stored_word[DATA_W-1:HALF], wr_data[HALF-1:0]};
            MODE_HIGH: merge_data = {wr_data[HALF-1:0], stored_word[HALF-1:0]};
            default:   merge_data = stored_word;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
            assign clr_hit[gi] = busy && (cnt_reg == ADDR_W'(gi));
            assign wr_hit[gi]  = wr_accept && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst || clr_hit[i]) begin
                regs[i] <= '0;
            end else if (wr_hit[i]) begin
                regs[i] <= merge_data;
            end
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (BYPASS && wr_accept && (wr_addr == rd_addr_a)) begin
            rd_data_a = merge_data;
        end
        if (R0_ZERO && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (BYPASS && wr_accept && (wr_addr == rd_addr_b)) begin
            rd_data_b = merge_data;
        end
        if (R0_ZERO && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end
    end

    // Flags follow the ALU regardless of the sweep; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_drop_next;
            if (flag_we) begin
                flag_c <= flag_c_in;
                flag_v <= flag_v_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_start) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(NUM_REGS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
